// File: rtl/u_game_judge_led_sched_pkg.sv
// Shared definitions for the judgement display scheduler and the LED driver:
// judge codes, scheduler state encoding and a small sizing helper.
package u_game_judge_led_sched_pkg;

  localparam logic [1:0] JUDGE_NONE    = 2'b00;
  localparam logic [1:0] JUDGE_MISS    = 2'b01;
  localparam logic [1:0] JUDGE_NORMAL  = 2'b10;
  localparam logic [1:0] JUDGE_PERFECT = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2,
    ST_OVER = 2'd3
  } sched_state_e;

  // Larger of two integers, used to size the shared hold/gap counter.
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/u_game_judge_led_sched_rr_arb.sv
// N-way round-robin arbiter. Purely combinational: the caller owns the
// pointer register. The search starts at i_ptr and wraps; the first pending
// lane found wins. o_any is 0 when nothing is pending.
module u_rr_arb #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  i_pend,
  input  logic [IW-1:0] i_ptr,
  output logic [N-1:0]  o_gnt,
  output logic [IW-1:0] o_idx,
  output logic          o_any
);

  int          j_int;
  logic [IW-1:0] j;
  logic        found;

  // Scan lanes from the pointer upward with wrap-around, pick the first pending one.
  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    found = 1'b0;
    j_int = 0;
    j     = '0;
    for (int i = 0; i < N; i++) begin
      j_int = (int'(i_ptr) + i) % N;
      j     = IW'(j_int);
      if (!found && i_pend[j]) begin
        found    = 1'b1;
        o_gnt[j] = 1'b1;
        o_idx    = j;
      end
    end
    o_any = found;
  end

endmodule

// File: rtl/u_game_judge_led_sched.sv
// Judgement display scheduler. Lane judges fire single-cycle strobes; each
// non-00 strobe is latched as a pending entry. Pending lanes are served
// round-robin: one judgement is shown for HOLD_MS ticks, then a blank gap of
// GAP_MS ticks. Game over flushes everything and hands the LED over.
// Strobe semantics: i_judge_vld[k] is sampled every clock, there is no
// back-pressure; a second event on a still-pending lane replaces the stored
// code and is reported on o_drop one cycle later.
module u_game_judge_led_sched
  import u_game_judge_led_sched_pkg::*;
#(
  parameter int N_LANE  = 4,
  parameter int HOLD_MS = 200,
  parameter int GAP_MS  = 50
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_tick,
  input  logic                      i_game_over,
  input  logic [N_LANE-1:0]         i_judge_vld,
  input  logic [2*N_LANE-1:0]       i_judge,
  output logic [1:0]                o_judge,
  output logic                      o_game_over,
  output logic [$clog2(N_LANE)-1:0] o_lane,
  output logic                      o_busy,
  output logic                      o_drop
);

  localparam int LW = $clog2(N_LANE);
  localparam int CW = $clog2(max_int(HOLD_MS, GAP_MS) + 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MS - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'((GAP_MS > 0) ? (GAP_MS - 1) : 0);
  localparam logic [LW-1:0] LANE_LAST = LW'(N_LANE - 1);

  sched_state_e          state_q;
  logic [CW-1:0]         cnt_q;
  logic [LW-1:0]         ptr_q;
  logic [N_LANE-1:0]     pend_q, pend_d;
  logic [2*N_LANE-1:0]   code_q, code_d;
  logic                  drop_q, drop_d;
  logic [1:0]            judge_q;
  logic [LW-1:0]         lane_q;
  logic                  busy_q;
  logic                  over_q;

  logic [N_LANE-1:0]     gnt;
  logic [LW-1:0]         gnt_idx;
  logic                  gnt_any;
  logic                  grant_en;
  logic [1:0]            gnt_code;
  logic [LW-1:0]         ptr_next;

  u_rr_arb #(
    .N  (N_LANE),
    .IW (LW)
  ) u_arb (
    .i_pend (pend_q),
    .i_ptr  (ptr_q),
    .o_gnt  (gnt),
    .o_idx  (gnt_idx),
    .o_any  (gnt_any)
  );

  // A grant only happens from IDLE and never in a cycle where game over is asserted.
  assign grant_en = (state_q == ST_IDLE) && !i_game_over && gnt_any;
  assign ptr_next = (gnt_idx == LANE_LAST) ? '0 : gnt_idx + 1'b1;

  // Select the stored code of the granted lane (old code, before any same-cycle capture).
  always_comb begin
    gnt_code = JUDGE_NONE;
    for (int k = 0; k < N_LANE; k++) begin
      if (gnt[k]) gnt_code = code_q[2*k +: 2];
    end
  end

  // Pending-table update: capture, overwrite detection, grant clear and game-over flush.
  always_comb begin
    pend_d = pend_q;
    code_d = code_q;
    drop_d = 1'b0;
    if (i_game_over || (state_q == ST_OVER)) begin
      pend_d = '0;
    end else begin
      if (grant_en) pend_d = pend_q & ~gnt;
      for (int k = 0; k < N_LANE; k++) begin
        if (i_judge_vld[k] && (i_judge[2*k +: 2] != JUDGE_NONE)) begin
          if (pend_q[k] && !(grant_en && gnt[k])) drop_d = 1'b1;
          pend_d[k]         = 1'b1;
          code_d[2*k +: 2]  = i_judge[2*k +: 2];
        end
      end
    end
  end

  // Pending table and drop pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_q <= '0;
      code_q <= '0;
      drop_q <= 1'b0;
    end else begin
      pend_q <= pend_d;
      code_q <= code_d;
      drop_q <= drop_d;
    end
  end

  // Display FSM with registered outputs, hold/gap counter and round-robin pointer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      ptr_q   <= '0;
      judge_q <= JUDGE_NONE;
      lane_q  <= '0;
      busy_q  <= 1'b0;
      over_q  <= 1'b0;
    end else if (i_game_over) begin
      state_q <= ST_OVER;
      cnt_q   <= '0;
      judge_q <= JUDGE_NONE;
      busy_q  <= 1'b0;
      over_q  <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (grant_en) begin
            judge_q <= gnt_code;
            lane_q  <= gnt_idx;
            cnt_q   <= '0;
            ptr_q   <= ptr_next;
            busy_q  <= 1'b1;
            state_q <= ST_SHOW;
          end
        end
        ST_SHOW: begin
          if (i_tick) begin
            if (cnt_q == HOLD_LAST) begin
              judge_q <= JUDGE_NONE;
              cnt_q   <= '0;
              if (GAP_MS == 0) begin
                busy_q  <= 1'b0;
                state_q <= ST_IDLE;
              end else begin
                state_q <= ST_GAP;
              end
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (i_tick) begin
            if (cnt_q == GAP_LAST) begin
              cnt_q   <= '0;
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        ST_OVER: begin
          over_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign o_judge     = judge_q;
  assign o_game_over = over_q;
  assign o_lane      = lane_q;
  assign o_busy      = busy_q;
  assign o_drop      = drop_q;

endmodule

// File: tb/tb_u_game_judge_led_sched.sv
// Directed bench for the judgement display scheduler (N_LANE=4, HOLD_MS=3,
// GAP_MS=2). Inputs change 1 ns after a rising edge; outputs are checked at
// the same point, so each check sees the result of the preceding edge.
module tb_u_game_judge_led_sched;

  logic       clk;
  logic       rst_n;
  logic       i_tick;
  logic       i_game_over;
  logic [3:0] i_judge_vld;
  logic [7:0] i_judge;
  logic [1:0] o_judge;
  logic       o_game_over;
  logic [1:0] o_lane;
  logic       o_busy;
  logic       o_drop;

  int n_checks = 0;
  int n_errors = 0;

  u_game_judge_led_sched #(
    .N_LANE  (4),
    .HOLD_MS (3),
    .GAP_MS  (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_tick      (i_tick),
    .i_game_over (i_game_over),
    .i_judge_vld (i_judge_vld),
    .i_judge     (i_judge),
    .o_judge     (o_judge),
    .o_game_over (o_game_over),
    .o_lane      (o_lane),
    .o_busy      (o_busy),
    .o_drop      (o_drop)
  );

  // Clock and watchdog
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [3:0] vld, input logic [7:0] codes);
    i_judge_vld = vld;
    i_judge     = codes;
    cyc();
    i_judge_vld = '0;
    i_judge     = '0;
  endtask

  task automatic pulse_tick();
    i_tick = 1'b1;
    cyc();
    i_tick = 1'b0;
    cyc();
  endtask

  // Three ticks of hold, check blank gap, two ticks of gap.
  task automatic hold_and_gap(input string tag);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    chk({tag, "_gap_judge"}, 8'(o_judge), 8'h0);
    chk({tag, "_gap_busy"},  8'(o_busy),  8'h1);
    pulse_tick();
    pulse_tick();
  endtask

  initial begin
    rst_n       = 1'b1;
    i_tick      = 1'b0;
    i_game_over = 1'b0;
    i_judge_vld = '0;
    i_judge     = '0;

    // Reset values
    #3 rst_n = 1'b0;
    #1;
    chk("rst_judge", 8'(o_judge), 8'h0);
    chk("rst_over",  8'(o_game_over), 8'h0);
    chk("rst_lane",  8'(o_lane), 8'h0);
    chk("rst_busy",  8'(o_busy), 8'h0);
    chk("rst_drop",  8'(o_drop), 8'h0);
    cyc();
    cyc();
    rst_n = 1'b1;
    cyc();

    // Round-robin: lanes 0 (Miss), 1 (Normal), 3 (Perfect) together, pointer 0
    strobe(4'b1011, 8'b11_00_10_01);
    chk("rr_capture_judge", 8'(o_judge), 8'h0);
    chk("rr_capture_busy",  8'(o_busy),  8'h0);
    cyc();
    chk("rr_g0_lane",  8'(o_lane),  8'h0);
    chk("rr_g0_judge", 8'(o_judge), 8'h1);
    chk("rr_g0_busy",  8'(o_busy),  8'h1);
    hold_and_gap("rr_g0");
    chk("rr_g1_lane",  8'(o_lane),  8'h1);
    chk("rr_g1_judge", 8'(o_judge), 8'h2);
    hold_and_gap("rr_g1");
    chk("rr_g3_lane",  8'(o_lane),  8'h3);
    chk("rr_g3_judge", 8'(o_judge), 8'h3);
    hold_and_gap("rr_g3");
    chk("rr_end_busy",  8'(o_busy),  8'h0);
    chk("rr_end_judge", 8'(o_judge), 8'h0);

    // Single event: lane 2 Perfect, pointer 0 -> grant lane 2, pointer 3
    strobe(4'b0100, 8'h30);
    chk("single_pre_judge", 8'(o_judge), 8'h0);
    cyc();
    chk("single_judge", 8'(o_judge), 8'h3);
    chk("single_lane",  8'(o_lane),  8'h2);
    chk("single_busy",  8'(o_busy),  8'h1);
    cyc();
    cyc();
    cyc();
    chk("single_no_tick_hold", 8'(o_judge), 8'h3);
    pulse_tick();
    pulse_tick();
    chk("single_tick2_judge", 8'(o_judge), 8'h3);
    pulse_tick();
    chk("single_tick3_judge", 8'(o_judge), 8'h0);
    chk("single_tick3_busy",  8'(o_busy),  8'h1);
    chk("single_tick3_lane",  8'(o_lane),  8'h2);
    pulse_tick();
    chk("single_gap1_busy", 8'(o_busy), 8'h1);
    pulse_tick();
    chk("single_gap2_busy", 8'(o_busy), 8'h0);

    // Lanes 0 (Normal) and 3 (Miss) together with pointer 3 -> 3 then 0
    strobe(4'b1001, 8'b01_00_00_10);
    cyc();
    chk("rr2_first_lane",  8'(o_lane),  8'h3);
    chk("rr2_first_judge", 8'(o_judge), 8'h1);
    hold_and_gap("rr2_first");
    chk("rr2_second_lane",  8'(o_lane),  8'h0);
    chk("rr2_second_judge", 8'(o_judge), 8'h2);
    hold_and_gap("rr2_second");
    chk("rr2_end_busy", 8'(o_busy), 8'h0);

    // Overwrite: lane 1 Miss then Normal while lane 0 is shown
    strobe(4'b0001, 8'h03);
    cyc();
    chk("ovw_show_lane", 8'(o_lane), 8'h0);
    strobe(4'b0010, 8'h04);
    chk("ovw_first_drop", 8'(o_drop), 8'h0);
    strobe(4'b0010, 8'h08);
    chk("ovw_second_drop", 8'(o_drop), 8'h1);
    cyc();
    chk("ovw_drop_clear", 8'(o_drop), 8'h0);
    hold_and_gap("ovw_l0");
    chk("ovw_l1_lane",  8'(o_lane),  8'h1);
    chk("ovw_l1_judge", 8'(o_judge), 8'h2);
    hold_and_gap("ovw_l1");
    chk("ovw_end_busy", 8'(o_busy), 8'h0);

    // Game over mid-SHOW with lanes 0 and 1 pending, plus a same-cycle event on lane 3
    strobe(4'b0100, 8'h30);
    cyc();
    chk("go_show_lane", 8'(o_lane), 8'h2);
    strobe(4'b0011, 8'b00_00_10_01);
    i_game_over = 1'b1;
    i_judge_vld = 4'b1000;
    i_judge     = 8'hC0;
    cyc();
    i_judge_vld = '0;
    i_judge     = '0;
    chk("go_over",  8'(o_game_over), 8'h1);
    chk("go_judge", 8'(o_judge), 8'h0);
    chk("go_busy",  8'(o_busy),  8'h0);
    cyc();
    i_judge_vld = 4'b0010;
    i_judge     = 8'h04;
    cyc();
    i_judge_vld = '0;
    i_judge     = '0;
    cyc();
    chk("go_in_over_drop",  8'(o_drop),  8'h0);
    chk("go_in_over_judge", 8'(o_judge), 8'h0);
    i_game_over = 1'b0;
    cyc();
    chk("go_release_over", 8'(o_game_over), 8'h0);
    cyc();
    cyc();
    chk("go_flushed_busy",  8'(o_busy),  8'h0);
    chk("go_flushed_judge", 8'(o_judge), 8'h0);

    // Ignored 00 code
    strobe(4'b0010, 8'h00);
    cyc();
    cyc();
    chk("ign_busy", 8'(o_busy), 8'h0);
    chk("ign_drop", 8'(o_drop), 8'h0);

    // Capture on the granting lane: grant uses Miss, Normal stays pending, no drop
    strobe(4'b0010, 8'h04);
    i_judge_vld = 4'b0010;
    i_judge     = 8'h08;
    cyc();
    i_judge_vld = '0;
    i_judge     = '0;
    chk("cog_lane",  8'(o_lane),  8'h1);
    chk("cog_judge", 8'(o_judge), 8'h1);
    chk("cog_drop",  8'(o_drop),  8'h0);
    hold_and_gap("cog_first");
    chk("cog_again_lane",  8'(o_lane),  8'h1);
    chk("cog_again_judge", 8'(o_judge), 8'h2);
    hold_and_gap("cog_again");
    chk("cog_end_busy", 8'(o_busy), 8'h0);

    // Reset mid-GAP with lane 1 pending; pointer 3 before reset
    strobe(4'b0100, 8'h30);
    cyc();
    chk("rg_show_lane", 8'(o_lane), 8'h2);
    pulse_tick();
    pulse_tick();
    pulse_tick();
    chk("rg_in_gap_busy", 8'(o_busy), 8'h1);
    strobe(4'b0010, 8'h04);
    #2;
    rst_n = 1'b0;
    #1;
    chk("rg_async_busy",  8'(o_busy),  8'h0);
    chk("rg_async_lane",  8'(o_lane),  8'h0);
    chk("rg_async_judge", 8'(o_judge), 8'h0);
    chk("rg_async_over",  8'(o_game_over), 8'h0);
    cyc();
    rst_n = 1'b1;
    pulse_tick();
    cyc();
    cyc();
    chk("rg_empty_busy", 8'(o_busy), 8'h0);
    // Pointer back to 0: lanes 1 and 3 pending -> lane 1 first
    strobe(4'b1010, 8'b01_00_10_00);
    cyc();
    chk("rg_ptr_lane",  8'(o_lane),  8'h1);
    chk("rg_ptr_judge", 8'(o_judge), 8'h2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/u_game_judge_led_sched.md
# u_game_judge_led_sched

Judgement display scheduler placed between the per-lane note judges and the full-colour LED driver. It captures judgement events from N_LANE lanes, arbitrates them round-robin, and presents one judgement at a time on the LED driver's judge input for a fixed hold time, followed by an optional blank gap. It also owns the game-over handover: on game over it flushes all pending events and passes control to the LED driver's end-of-game animation.

## Interface
- N_LANE, 4, number of judging lanes (2..8)
- HOLD_MS, 200, ticks a granted judgement is displayed (>=1)
- GAP_MS, 50, ticks of blank (judge 00) after each hold; 0 = no gap
- clk  in  1  system clock
- rst_n  in  1  asynchronous, active-low reset
- i_tick  in  1  1 ms single-cycle strobe
- i_game_over  in  1  level; 1 = game ended
- i_judge_vld  in  N_LANE  per-lane single-cycle event strobe
- i_judge  in  2*N_LANE  per-lane judge code, lane k at [2k+1:2k]; 01 Miss, 10 Normal, 11 Perfect, 00 None
- o_judge  out  2  judge code to LED driver
- o_game_over  out  1  game-over level to LED driver
- o_lane  out  $clog2(N_LANE)  lane index of the displayed judgement
- o_busy  out  1  1 in SHOW or GAP
- o_drop  out  1  single-cycle pulse: a pending event was overwritten

## Operation
- Reset: o_judge=00, o_game_over=0, o_lane=0, o_busy=0, o_drop=0; all pending cleared; RR pointer=0; state IDLE.
- Capture: i_judge_vld[k]=1 with a non-00 code sets pending[k] and stores the code. A 00 code is ignored. If lane k is already pending and not being granted this cycle, the new code overwrites the stored code and o_drop pulses on the next cycle.
- Arbitration: round-robin over pending lanes, starting at the RR pointer. After lane k is granted, the pointer becomes (k+1) mod N_LANE.
- States:
  - IDLE: if any lane is pending, grant it. o_judge takes the stored code, o_lane takes the lane index, pending[k] clears, hold counter clears, and the state moves to SHOW.
  - SHOW: on each i_tick, the counter increments. On the tick where the counter equals HOLD_MS-1, the state moves to GAP, or to IDLE when GAP_MS=0. o_judge is set to 00 on that transition.
  - GAP: o_judge=00. The counter counts GAP_MS ticks the same way, then the state moves to IDLE.
  - OVER: entered from any state when i_game_over=1. All pending entries clear, o_judge=00, o_busy=0, o_game_over=1, and new events are ignored. When i_game_over=0, the state moves to IDLE, o_game_over=0, and the RR pointer is kept.
- Simultaneous events:
  - A capture on lane k in the same cycle that lane k is granted: the grant uses the old stored code, the new event stays pending, and o_drop does not pulse.
  - A capture in the same cycle that i_game_over rises: the event is discarded.
- Counters are $clog2(max(HOLD_MS,GAP_MS)+1) bits wide and never wrap; they count only on i_tick.

## Timing
- Event strobe in cycle t: pending is set at edge t+1. If the block is IDLE, the grant occurs at edge t+2, and o_judge/o_lane are valid from cycle t+2.
- Display length is exactly HOLD_MS tick strobes. The first tick counted is the first one strictly after the grant edge.
- The next grant occurs in the cycle after the return to IDLE, so back-to-back events are separated by one clk cycle of 00 when GAP_MS=0.
- i_game_over rising at cycle t: OVER and o_game_over=1 from edge t+1.
- Asynchronous reset takes effect immediately, mid-SHOW included. Outputs go to their reset values without waiting for clk.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Shared package: the judge code constants JUDGE_NONE/MISS/NORMAL/PERFECT (also used by the LED driver) and the state encoding IDLE/SHOW/GAP/OVER.
- Sub-module: u_rr_arb, a parameterised N-way round-robin arbiter with pending mask and pointer in, one-hot grant plus index out, combinational. The scheduler holds the pointer register.

## Test plan
- Single event: lane 2 Perfect at cycle 10, HOLD_MS=3, GAP_MS=0 -> o_judge=11 and o_lane=2 from cycle 12 until the 3rd tick after the grant, then 00; o_busy mirrors this window.
- Round-robin: lanes 0, 1 and 3 strobe in the same cycle -> grants occur in the order 0, 1, 3. Then lanes 0 and 3 strobe together -> order 3, 0 (pointer=0 after granting 3, so 0 next; verify lane 3 was pending first).
- Overwrite: lane 1 Miss then lane 1 Normal while SHOW is displaying lane 0 -> o_drop pulses once, and lane 1 later displays 10.
- Game over mid-SHOW: i_game_over=1 with 2 lanes pending -> next cycle o_game_over=1, o_judge=00; after i_game_over=0, IDLE with nothing displayed.
- Reset mid-GAP: rst_n low for 1 cycle -> all outputs at reset values immediately; pending is empty afterward.
- Ignored input: vld with code 00, and vld while in OVER -> no grant and no o_drop.
